rv_lsu_handshake: RTL and testbench

Parametrised load/store unit for the MEMORY stage. It generalises the fixed single-cycle 32-bit access logic to XLEN of 32 or 64 and to a req/ack data-memory handshake with variable wait states. It also adds misaligned/illegal-access detection and an ack-timeout bus error. It stalls the pipeline while an access is outstanding and returns zero- or sign-extended load data.

---
 rtl/rv_lsu_handshake.sv | 151 +++++++++++++++
 tb/tb_rv_lsu_handshake.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu_handshake.sv
// Load/store unit for the MEMORY stage: req/ack data-memory handshake with wait states,
// alignment/legality checks, ack timeout and zero/sign-extended load return.
module rv_lsu_handshake #(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_store,
    input  logic [2:0]        i_funct3,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_rs2,
    output logic              o_ready,
    output logic              o_stall,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [XLEN/8-1:0] o_mem_wmask,
    input  logic              i_mem_ack,
    input  logic [XLEN-1:0]   i_mem_rdata,
    output logic              o_done,
    output logic [XLEN-1:0]   o_data_load,
    output logic              o_misaligned,
    output logic              o_illegal,
    output logic              o_bus_err
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IDXW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [15:0]       cnt;
    logic [OFFW-1:0]   off, off_q;
    logic [1:0]        size, size_q;
    logic              sext_q, load_q;
    logic              illegal, misaligned;
    logic [NB-1:0]     bmask;
    logic [XLEN-1:0]   sh, load_ext;
    logic              fill;
    int                nbits;

    assign off  = i_addr[OFFW-1:0];
    assign size = i_funct3[1:0];

    always_comb begin
        illegal = (i_funct3 == 3'b111) || (i_store && i_funct3[2]);
        if (XLEN == 32 && (i_funct3 == 3'b011 || i_funct3 == 3'b110))
            illegal = 1'b1;
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = i_addr[0];
            2'd2:    misaligned = |i_addr[1:0];
            default: misaligned = |i_addr[2:0];
        endcase
        for (int i = 0; i < NB; i++)
            bmask[i] = (i < (1 << size));
    end

    // Lane-shift the read data, then extend from the top bit of the access size.
    always_comb begin
        sh    = i_mem_rdata >> {off_q, 3'b000};
        nbits = 8 << size_q;
        if (nbits > XLEN)
            nbits = XLEN;
        fill = sext_q & sh[IDXW'(nbits - 1)];
        for (int i = 0; i < XLEN; i++)
            load_ext[i] = (i < nbits) ? sh[i] : fill;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            off_q        <= '0;
            size_q       <= '0;
            sext_q       <= 1'b0;
            load_q       <= 1'b0;
            o_ready      <= 1'b1;
            o_stall      <= 1'b0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_wmask  <= '0;
            o_done       <= 1'b0;
            o_data_load  <= '0;
            o_misaligned <= 1'b0;
            o_illegal    <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        o_ready <= 1'b0;
                        o_stall <= 1'b1;
                        if (illegal || misaligned) begin
                            state        <= RESP;
                            o_done       <= 1'b1;
                            o_illegal    <= illegal;
                            o_misaligned <= !illegal && misaligned;
                            o_data_load  <= '0;
                        end else begin
                            state       <= WAIT;
                            cnt         <= '0;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_store;
                            o_mem_addr  <= {i_addr[XLEN-1:OFFW], OFFW'(0)};
                            o_mem_wdata <= i_rs2 << {off, 3'b000};
                            o_mem_wmask <= i_store ? (bmask << off) : '0;
                            off_q       <= off;
                            size_q      <= size;
                            sext_q      <= !i_funct3[2];
                            load_q      <= !i_store;
                        end
                    end
                end
                WAIT: begin
                    // An ack in the timeout cycle still completes normally.
                    if (i_mem_ack) begin
                        state       <= RESP;
                        o_mem_req   <= 1'b0;
                        o_done      <= 1'b1;
                        o_data_load <= load_q ? load_ext : '0;
                    end else if (cnt == 16'(ACK_TIMEOUT - 1)) begin
                        state       <= RESP;
                        o_mem_req   <= 1'b0;
                        o_done      <= 1'b1;
                        o_bus_err   <= 1'b1;
                        o_data_load <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    o_ready      <= 1'b1;
                    o_stall      <= 1'b0;
                    o_done       <= 1'b0;
                    o_misaligned <= 1'b0;
                    o_illegal    <= 1'b0;
                    o_bus_err    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv_lsu_handshake.sv
// Directed bench: a 32-bit unit with a short ack timeout and a 64-bit unit, driven
// from a table of accesses plus a reset-during-WAIT sequence.
module tb_rv_lsu_handshake;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel64 = 1'b0;
    logic        valid = 1'b0, store = 1'b0, ack = 1'b0;
    logic [2:0]  f3 = 3'b0;
    logic [63:0] addr = '0, rs2 = '0, rdata = '0;

    logic        r32, s32, q32, we32, d32, m32, i32, b32;
    logic [31:0] a32, w32, l32;
    logic [3:0]  k32;
    logic        r64, s64, q64, we64, d64, m64, i64, b64;
    logic [63:0] a64, w64, l64;
    logic [7:0]  k64;

    logic        m_ready, m_stall, m_req, m_we, m_done, m_mis, m_ill, m_bus;
    logic [63:0] m_addr, m_wdata, m_load;
    logic [7:0]  m_mask;

    int total = 0, passed = 0;

    always #5 clk = ~clk;

    rv_lsu_handshake #(.XLEN(32), .ACK_TIMEOUT(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .i_valid(valid && !sel64), .i_store(store), .i_funct3(f3),
        .i_addr(addr[31:0]), .i_rs2(rs2[31:0]), .o_ready(r32), .o_stall(s32), .o_mem_req(q32),
        .o_mem_we(we32), .o_mem_addr(a32), .o_mem_wdata(w32), .o_mem_wmask(k32),
        .i_mem_ack(ack && !sel64), .i_mem_rdata(rdata[31:0]), .o_done(d32), .o_data_load(l32),
        .o_misaligned(m32), .o_illegal(i32), .o_bus_err(b32));

    rv_lsu_handshake #(.XLEN(64), .ACK_TIMEOUT(255)) dut64 (
        .clk(clk), .rst_n(rst_n), .i_valid(valid && sel64), .i_store(store), .i_funct3(f3),
        .i_addr(addr), .i_rs2(rs2), .o_ready(r64), .o_stall(s64), .o_mem_req(q64),
        .o_mem_we(we64), .o_mem_addr(a64), .o_mem_wdata(w64), .o_mem_wmask(k64),
        .i_mem_ack(ack && sel64), .i_mem_rdata(rdata), .o_done(d64), .o_data_load(l64),
        .o_misaligned(m64), .o_illegal(i64), .o_bus_err(b64));

    assign m_ready = sel64 ? r64  : r32;
    assign m_stall = sel64 ? s64  : s32;
    assign m_req   = sel64 ? q64  : q32;
    assign m_we    = sel64 ? we64 : we32;
    assign m_done  = sel64 ? d64  : d32;
    assign m_mis   = sel64 ? m64  : m32;
    assign m_ill   = sel64 ? i64  : i32;
    assign m_bus   = sel64 ? b64  : b32;
    assign m_addr  = sel64 ? a64  : {32'b0, a32};
    assign m_wdata = sel64 ? w64  : {32'b0, w32};
    assign m_load  = sel64 ? l64  : {32'b0, l32};
    assign m_mask  = sel64 ? k64  : {4'b0, k32};

    typedef struct {
        logic        sel64;
        logic        store;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] rs2;
        int          waits;      // wait cycles before ack; large value = never ack
        logic [63:0] rdata;
        logic [63:0] exp_addr;
        logic [7:0]  exp_mask;
        logic [63:0] exp_wdata;
        logic [63:0] exp_data;
        logic [2:0]  exp_flags;  // {illegal, misaligned, bus_err}
        int          exp_lat;
        int          exp_req;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  reqcnt = 0, lat = -1;
        bit  fields_checked = 0;
        sel64 = v.sel64;
        store = v.store; f3 = v.f3; addr = v.addr; rs2 = v.rs2; rdata = v.rdata;
        valid = 1'b1;
        #1;
        chk($sformatf("v%0d ready_before", idx), {63'b0, m_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            ack = 1'b0;
            if (m_done) begin
                lat = k + 1;
                break;
            end
            if (m_req) begin
                if (!fields_checked) begin
                    fields_checked = 1;
                    chk($sformatf("v%0d mem_addr", idx), m_addr, v.exp_addr);
                    chk($sformatf("v%0d wmask", idx), {56'b0, m_mask}, {56'b0, v.exp_mask});
                    chk($sformatf("v%0d wdata", idx), m_wdata, v.exp_wdata);
                    chk($sformatf("v%0d we", idx), {63'b0, m_we}, {63'b0, v.store});
                end
                ack = (reqcnt == v.waits);
                reqcnt++;
            end
            @(negedge clk);
        end
        ack = 1'b0;
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("v%0d req_cycles", idx), 64'(reqcnt), 64'(v.exp_req));
        chk($sformatf("v%0d flags", idx), {61'b0, m_ill, m_mis, m_bus}, {61'b0, v.exp_flags});
        chk($sformatf("v%0d data_load", idx), m_load, v.exp_data);
        @(negedge clk);
        chk($sformatf("v%0d done_pulse", idx), {62'b0, m_done, m_ready}, 64'b01);
    endtask

    function automatic vec_t mk(input logic s64, input logic st, input logic [2:0] fn,
                                input logic [63:0] a, input logic [63:0] d, input int w,
                                input logic [63:0] rd, input logic [63:0] ea,
                                input logic [7:0] em, input logic [63:0] ew,
                                input logic [63:0] ed, input logic [2:0] fl,
                                input int el, input int er);
        vec_t v;
        v.sel64 = s64; v.store = st; v.f3 = fn; v.addr = a; v.rs2 = d; v.waits = w;
        v.rdata = rd; v.exp_addr = ea; v.exp_mask = em; v.exp_wdata = ew; v.exp_data = ed;
        v.exp_flags = fl; v.exp_lat = el; v.exp_req = er;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(0, 0, 3'b000, 64'h103, 0, 2, 64'h8000_0000, 64'h100, 8'h0, 0, 64'hFFFF_FF80, 3'b000, 4, 3);
        vecs[1]  = mk(0, 0, 3'b100, 64'h103, 0, 2, 64'h8000_0000, 64'h100, 8'h0, 0, 64'h80, 3'b000, 4, 3);
        vecs[2]  = mk(0, 1, 3'b001, 64'h2, 64'hBEEF, 0, 0, 64'h0, 8'hC, 64'hBEEF_0000, 0, 3'b000, 2, 1);
        vecs[3]  = mk(0, 0, 3'b011, 64'h0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0);
        vecs[4]  = mk(0, 0, 3'b001, 64'h1, 0, 0, 0, 0, 0, 0, 0, 3'b010, 1, 0);
        vecs[5]  = mk(0, 1, 3'b100, 64'h0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0);
        vecs[6]  = mk(0, 0, 3'b010, 64'h4, 0, 999, 0, 64'h4, 8'h0, 0, 0, 3'b001, 5, 4);
        vecs[7]  = mk(0, 0, 3'b010, 64'h8, 0, 3, 64'h1234_5678, 64'h8, 8'h0, 0, 64'h1234_5678, 3'b000, 5, 4);
        vecs[8]  = mk(0, 0, 3'b101, 64'h6, 0, 0, 64'hABCD_0000, 64'h4, 8'h0, 0, 64'hABCD, 3'b000, 2, 1);
        vecs[9]  = mk(0, 0, 3'b001, 64'h6, 0, 1, 64'hABCD_0000, 64'h4, 8'h0, 0, 64'hFFFF_ABCD, 3'b000, 3, 2);
        vecs[10] = mk(1, 0, 3'b011, 64'h8, 0, 1, 64'h8000_0000_0000_0001, 64'h8, 8'h0, 0,
                      64'h8000_0000_0000_0001, 3'b000, 3, 2);
        vecs[11] = mk(1, 0, 3'b010, 64'hC, 0, 0, 64'h8000_0000_0000_0000, 64'h8, 8'h0, 0,
                      64'hFFFF_FFFF_8000_0000, 3'b000, 2, 1);
        vecs[12] = mk(1, 1, 3'b011, 64'h4, 64'h55, 0, 0, 0, 0, 0, 0, 3'b010, 1, 0);
        vecs[13] = mk(1, 0, 3'b110, 64'hC, 0, 0, 64'h8000_0000_0000_0000, 64'h8, 8'h0, 0,
                      64'h8000_0000, 3'b000, 2, 1);
        vecs[14] = mk(1, 0, 3'b111, 64'h0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 0);
        vecs[15] = mk(1, 1, 3'b010, 64'h4, 64'h1122_3344, 0, 0, 64'h0, 8'hF0,
                      64'h1122_3344_0000_0000, 0, 3'b000, 2, 1);

        repeat (3) @(negedge clk);
        chk("reset32", {59'b0, r32, s32, q32, d32, l32 != 0}, 64'b10000);
        chk("reset64", {59'b0, r64, s64, q64, d64, l64 != 0}, 64'b10000);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            run_vec(i, vecs[i]);

        // Reset while a request is outstanding, then a stale ack after release.
        sel64 = 1'b0; store = 1'b0; f3 = 3'b010; addr = 64'h10; rdata = 64'hDEAD_BEEF;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        chk("rst_seq req_before", {63'b0, q32}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_seq after_reset", {61'b0, q32, r32, s32}, 64'b010);
        rst_n = 1'b1;
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 4; k++) begin
                if (d32 || !r32 || q32) seen++;
                @(negedge clk);
            end
            chk("rst_seq stale_ack_ignored", 64'(seen), 64'd0);
        end
        run_vec(16, vecs[7]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end
endmodule
